matrix_row_reduce: RTL and testbench

- Downstream stage of the matrix-times-vector element multiplier.
- The multiplier produces a flat bus of per-element products. This block captures that bus and reduces each row to one sum, serially, one product per cycle.
- It presents the final matrix-vector result vector with a valid flag.
- It sits between the multiplier and any consumer of the resulting vector.

---
 rtl/matrix_ops_pkg.sv | 28 ++
 rtl/matrix_idx_counter.sv | 60 ++++++
 rtl/matrix_row_reduce.sv | 155 +++++++++++++++
 tb/tb_matrix_row_reduce.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/matrix_ops_pkg.sv
// ----------------------------------------------------------------------------
// matrix_ops_pkg
// Shared definitions for the matrix-vector pipeline stages (row reduce,
// transpose, matrix-matrix).
//   - Default matrix geometry and derived bus and accumulator widths.
//   - FSM state encoding used by the serial reduction stage.
//   - idx_w(): counter width for n positions, never less than one bit.
// ----------------------------------------------------------------------------
package matrix_ops_pkg;

  localparam int DEF_MATRIX_WIDTH  = 5;
  localparam int DEF_MATRIX_HEIGHT = 5;
  localparam int DEF_DATA_WIDTH    = 8;

  localparam int DEF_MATRIX_SIZE = DEF_MATRIX_WIDTH * DEF_MATRIX_HEIGHT * DEF_DATA_WIDTH;
  // A row sum of W unsigned terms needs clog2(W) extra bits, so it cannot overflow.
  localparam int DEF_ACC_WIDTH   = DEF_DATA_WIDTH + $clog2(DEF_MATRIX_WIDTH);

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_ACCUM    = 2'd1;
  localparam logic [1:0] ST_WAIT_LOW = 2'd2;

  // $clog2(1) is 0. A zero-width index is illegal, so clamp it to 1 bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/matrix_idx_counter.sv
// ----------------------------------------------------------------------------
// matrix_idx_counter
// Row/column walker for a WIDTH x HEIGHT matrix in row-major order.
// The column advances on each enabled cycle. At the end of a row the column
// wraps to 0 and the row advances. After the last term both indices wrap to 0.
// Ports:
//   clk, i_rst_n : clock; synchronous active-low reset
//   clear        : force both indices to 0 (start of an operation)
//   advance      : step to the next element
//   row, col     : current element position
//   last_col     : col is the final column of the row
//   last_term    : row and col both point at the final element
// ----------------------------------------------------------------------------
module matrix_idx_counter
  import matrix_ops_pkg::*;
#(
  parameter int WIDTH  = DEF_MATRIX_WIDTH,
  parameter int HEIGHT = DEF_MATRIX_HEIGHT,
  parameter int ROW_W  = idx_w(HEIGHT),
  parameter int COL_W  = idx_w(WIDTH)
) (
  input  logic             clk,
  input  logic             i_rst_n,
  input  logic             clear,
  input  logic             advance,
  output logic [ROW_W-1:0] row,
  output logic [COL_W-1:0] col,
  output logic             last_col,
  output logic             last_term
);

  logic [ROW_W-1:0] row_reg;
  logic [COL_W-1:0] col_reg;
  logic             last_row;

  assign last_col  = (col_reg == COL_W'(WIDTH - 1));
  assign last_row  = (row_reg == ROW_W'(HEIGHT - 1));
  assign last_term = last_col & last_row;

  always_ff @(posedge clk) begin
    if (!i_rst_n) begin
      row_reg <= '0;
      col_reg <= '0;
    end else if (clear) begin
      row_reg <= '0;
      col_reg <= '0;
    end else if (advance) begin
      if (last_col) begin
        col_reg <= '0;
        row_reg <= last_row ? '0 : row_reg + 1'b1;
      end else begin
        col_reg <= col_reg + 1'b1;
      end
    end
  end

  assign row = row_reg;
  assign col = col_reg;

endmodule

// File: rtl/matrix_row_reduce.sv
// ----------------------------------------------------------------------------
// matrix_row_reduce
// Captures the flat product bus from the element multiplier. Each matrix row
// is then summed serially, one product per clock. The block presents the
// resulting vector with a one-cycle valid pulse.
// Ports:
//   clk, i_rst_n : clock; synchronous active-low reset
//   i_valid      : products valid. This is a level signal and is only
//                  acted on in IDLE.
//   i_products   : product (r,c) at slice (r*MATRIX_WIDTH+c)*DATA_WIDTH
//   o_busy       : high while the captured matrix is being accumulated
//   o_valid      : one-cycle pulse once every row sum is in o_result
//   o_result     : row sum r at slice r*ACC_WIDTH (unsigned)
// ----------------------------------------------------------------------------
module matrix_row_reduce
  import matrix_ops_pkg::*;
#(
  parameter int MATRIX_WIDTH  = DEF_MATRIX_WIDTH,
  parameter int MATRIX_HEIGHT = DEF_MATRIX_HEIGHT,
  parameter int DATA_WIDTH    = DEF_DATA_WIDTH,
  parameter int ACC_WIDTH     = DATA_WIDTH + $clog2(MATRIX_WIDTH),
  parameter int MATRIX_SIZE   = MATRIX_WIDTH * MATRIX_HEIGHT * DATA_WIDTH,
  parameter int RESULT_SIZE   = MATRIX_HEIGHT * ACC_WIDTH
) (
  input  logic                   clk,
  input  logic                   i_rst_n,
  input  logic                   i_valid,
  input  logic [MATRIX_SIZE-1:0] i_products,
  output logic                   o_busy,
  output logic                   o_valid,
  output logic [RESULT_SIZE-1:0] o_result
);

  localparam int NUM_TERMS = MATRIX_WIDTH * MATRIX_HEIGHT;
  localparam int ROW_W     = idx_w(MATRIX_HEIGHT);
  localparam int COL_W     = idx_w(MATRIX_WIDTH);
  localparam int IDX_W     = idx_w(NUM_TERMS);

  logic [1:0]             state_reg;
  logic [MATRIX_SIZE-1:0] cap_reg;
  logic [ACC_WIDTH-1:0]   acc_reg;
  logic [ACC_WIDTH-1:0]   acc_next;
  logic                   busy_reg;
  logic                   valid_reg;

  logic [ROW_W-1:0]       row_idx;
  logic [COL_W-1:0]       col_idx;
  logic                   last_col;
  logic                   last_term;
  logic                   start;
  logic                   in_accum;
  logic                   row_write;

  logic [DATA_WIDTH-1:0]  term_arr [NUM_TERMS];
  logic [IDX_W-1:0]       term_idx;
  logic [DATA_WIDTH-1:0]  term;

  assign start     = (state_reg == ST_IDLE) && i_valid;
  assign in_accum  = (state_reg == ST_ACCUM);
  assign row_write = in_accum && last_col;

  // --------------------------------------------------------------------------
  // Element walker
  // --------------------------------------------------------------------------
  matrix_idx_counter #(
    .WIDTH  (MATRIX_WIDTH),
    .HEIGHT (MATRIX_HEIGHT),
    .ROW_W  (ROW_W),
    .COL_W  (COL_W)
  ) u_idx (
    .clk       (clk),
    .i_rst_n   (i_rst_n),
    .clear     (start),
    .advance   (in_accum),
    .row       (row_idx),
    .col       (col_idx),
    .last_col  (last_col),
    .last_term (last_term)
  );

  // --------------------------------------------------------------------------
  // Term selection from the captured bus (row-major flat layout)
  // --------------------------------------------------------------------------
  for (genvar gi = 0; gi < NUM_TERMS; gi++) begin : g_term
    assign term_arr[gi] = cap_reg[gi*DATA_WIDTH +: DATA_WIDTH];
  end

  always_comb begin
    term_idx = IDX_W'(int'(row_idx) * MATRIX_WIDTH + int'(col_idx));
    term     = term_arr[term_idx];
    acc_next = acc_reg + ACC_WIDTH'(term);
  end

  // --------------------------------------------------------------------------
  // Control FSM and accumulator
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!i_rst_n) begin
      state_reg <= ST_IDLE;
      cap_reg   <= '0;
      acc_reg   <= '0;
      busy_reg  <= 1'b0;
      valid_reg <= 1'b0;
    end else begin
      valid_reg <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (i_valid) begin
            cap_reg   <= i_products;
            acc_reg   <= '0;
            busy_reg  <= 1'b1;
            state_reg <= ST_ACCUM;
          end
        end
        ST_ACCUM: begin
          // At the end of a row the sum goes to the row register, so the
          // accumulator restarts at zero for the next row.
          acc_reg <= last_col ? '0 : acc_next;
          if (last_term) begin
            valid_reg <= 1'b1;
            busy_reg  <= 1'b0;
            state_reg <= ST_WAIT_LOW;
          end
        end
        ST_WAIT_LOW: begin
          // i_valid stays high while upstream holds its inputs. Only a low
          // level re-arms the block, so one level never starts a second run.
          if (!i_valid) state_reg <= ST_IDLE;
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Per-row result registers, written when that row's last column is summed
  // --------------------------------------------------------------------------
  for (genvar gi = 0; gi < MATRIX_HEIGHT; gi++) begin : g_row
    logic [ACC_WIDTH-1:0] sum_reg;

    always_ff @(posedge clk) begin
      if (!i_rst_n) begin
        sum_reg <= '0;
      end else if (row_write && (row_idx == ROW_W'(gi))) begin
        sum_reg <= acc_next;
      end
    end

    assign o_result[gi*ACC_WIDTH +: ACC_WIDTH] = sum_reg;
  end

  assign o_busy  = busy_reg;
  assign o_valid = valid_reg;

endmodule

// File: tb/tb_matrix_row_reduce.sv
module tb_matrix_row_reduce;

  localparam int W   = 5;
  localparam int H   = 5;
  localparam int DW  = 8;
  localparam int AW  = 11;
  localparam int MS  = W * H * DW;
  localparam int RS  = H * AW;

  logic          clk;
  logic          i_rst_n;
  logic          i_valid;
  logic [MS-1:0] i_products;
  logic          o_busy;
  logic          o_valid;
  logic [RS-1:0] o_result;

  int checks   = 0;
  int failures = 0;

  matrix_row_reduce dut (
    .clk        (clk),
    .i_rst_n    (i_rst_n),
    .i_valid    (i_valid),
    .i_products (i_products),
    .o_busy     (o_busy),
    .o_valid    (o_valid),
    .o_result   (o_result)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Product (r,c) = base + per_row*r, the same value in every column of a row.
  function automatic logic [MS-1:0] fill(input int base, input int per_row);
    logic [MS-1:0] v;
    v = '0;
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++)
        v[(r*W+c)*DW +: DW] = DW'(base + per_row * r);
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present products with a single-cycle i_valid. Returns just after capture edge E0.
  task automatic start_op(input logic [MS-1:0] prod);
    i_products = prod;
    i_valid    = 1'b1;
    tick();
    i_valid    = 1'b0;
  endtask

  // Waits for o_valid, bounded by a cycle budget, then checks the latency,
  // the busy length, every row sum and the pulse width.
  task automatic wait_done(input string tag, input int skipped, input int exp_s [H]);
    int cycles;
    int busy_cnt;
    cycles   = skipped;
    busy_cnt = skipped;
    while (!o_valid && cycles < 200) begin
      if (o_busy) busy_cnt++;
      tick();
      cycles++;
    end
    check_val({tag, "_latency"}, 64'(cycles), 64'd25);
    check_val({tag, "_busy_len"}, 64'(busy_cnt), 64'd25);
    check_val({tag, "_busy_at_valid"}, 64'(o_busy), 64'd0);
    for (int r = 0; r < H; r++)
      check_val($sformatf("%s_row%0d", tag, r), 64'(o_result[r*AW +: AW]), 64'(exp_s[r]));
    tick();
    check_val({tag, "_pulse_len"}, 64'(o_valid), 64'd0);
    $display("op %s: latency=%0d result=0x%0h", tag, cycles, o_result);
  endtask

  initial begin
    int pulses;

    i_rst_n    = 1'b0;
    i_valid    = 1'b0;
    i_products = '0;
    repeat (3) tick();
    check_val("reset_busy", 64'(o_busy), 64'd0);
    check_val("reset_valid", 64'(o_valid), 64'd0);
    check_val("reset_result", 64'(o_result), 64'd0);
    $display("op reset: busy=%0d valid=%0d result=0x%0h", o_busy, o_valid, o_result);
    i_rst_n = 1'b1;
    tick();

    // All ones gives 5 per row.
    start_op(fill(1, 0));
    check_val("ones_busy_rise", 64'(o_busy), 64'd1);
    wait_done("ones", 0, '{5, 5, 5, 5, 5});

    // All 255 gives 1275 (11'h4FB), with no wrap.
    start_op(fill(255, 0));
    wait_done("max", 0, '{1275, 1275, 1275, 1275, 1275});

    // Row r = r+1 checks the row/column mapping.
    start_op(fill(1, 1));
    wait_done("rowmap", 0, '{5, 10, 15, 20, 25});

    // Held i_valid gives exactly one operation.
    i_products = fill(2, 0);
    i_valid    = 1'b1;
    pulses     = 0;
    repeat (40) begin
      tick();
      if (o_valid) pulses++;
    end
    check_val("held_pulses", 64'(pulses), 64'd1);
    check_val("held_row0", 64'(o_result[0 +: AW]), 64'd10);
    check_val("held_row4", 64'(o_result[4*AW +: AW]), 64'd10);
    $display("op held: pulses=%0d result=0x%0h", pulses, o_result);
    // A one-cycle drop re-arms the block, so the next high level captures.
    i_valid = 1'b0;
    tick();
    i_valid    = 1'b1;
    i_products = fill(3, 0);
    tick();
    i_valid = 1'b0;
    wait_done("rearm", 0, '{15, 15, 15, 15, 15});

    // Upstream change at ACCUM cycle 10 must not affect the result.
    start_op(fill(4, 0));
    repeat (10) tick();
    i_products = fill(7, 0);
    wait_done("freeze", 10, '{20, 20, 20, 20, 20});

    // Reset in the middle of accumulation.
    start_op(fill(9, 0));
    repeat (11) tick();
    i_rst_n = 1'b0;
    tick();
    i_rst_n = 1'b1;
    check_val("midrst_result", 64'(o_result), 64'd0);
    check_val("midrst_busy", 64'(o_busy), 64'd0);
    check_val("midrst_valid", 64'(o_valid), 64'd0);
    pulses = 0;
    repeat (30) begin
      tick();
      if (o_valid || o_busy) pulses++;
    end
    check_val("midrst_quiet", 64'(pulses), 64'd0);
    $display("op midrst: result=0x%0h busy=%0d", o_result, o_busy);

    // Reset and i_valid at the same edge: reset wins.
    i_rst_n = 1'b0;
    i_valid = 1'b1;
    i_products = fill(8, 0);
    tick();
    i_valid = 1'b0;
    i_rst_n = 1'b1;
    check_val("rst_vs_valid_busy", 64'(o_busy), 64'd0);
    tick();
    check_val("rst_vs_valid_idle", 64'(o_busy), 64'd0);
    $display("op rst_vs_valid: busy=%0d", o_busy);

    // A fresh operation after reset completes normally.
    start_op(fill(6, 0));
    wait_done("post_rst", 0, '{30, 30, 30, 30, 30});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
